core_mc: RTL and testbench

Parametrised multi-cycle successor to the 8-bit demo core. It fetches 8-bit instructions from an external instruction memory over a req/ack handshake and keeps a 4-entry register file. It executes ALU, load-immediate, branch, output and halt instructions through a FETCH/EXEC state machine. It sits at the top of the core hierarchy, with instruction memory outside the block.

---
 rtl/core_mc.sv | 186 ++++++++++++++++++
 tb/tb_core_mc.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mc.sv
// core_mc: multi-cycle 8-bit-instruction core with a 4-entry register file.
// Fetches from external instruction memory over a req/ack handshake and runs a
// FETCH/EXEC state machine. Optional retired-instruction counter is built when
// the macro CORE_MC_RETIRE_CNT_EN is defined.
module core_mc #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PC_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
`ifdef CORE_MC_RETIRE_CNT_EN
  output logic              halted,
  output logic [15:0]       retire_cnt
`else
  output logic              halted
`endif
);

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

  localparam logic [1:0] OpAlu  = 2'b00;
  localparam logic [1:0] OpLi   = 2'b01;
  localparam logic [1:0] OpBeqz = 2'b10;
  localparam logic [1:0] OpSpec = 2'b11;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [7:0]          ir_q, ir_d;
  logic [DATA_W-1:0]   regs_q [4];
  logic [DATA_W-1:0]   regs_d [4];
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                req_q, req_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;
`ifdef CORE_MC_RETIRE_CNT_EN
  logic [15:0]         retire_q, retire_d;
`endif

  // Instruction fields, always decoded from the latched IR.
  logic [1:0]          op;
  logic [1:0]          rd;
  logic [1:0]          rs1;
  logic [1:0]          funct;
  logic [3:0]          imm4;
  logic signed [3:0]   br_off;
  logic [DATA_W-1:0]   rd_val;
  logic [DATA_W-1:0]   rs1_val;
  logic [DATA_W-1:0]   alu_res;

  assign op      = ir_q[7:6];
  assign rd      = ir_q[5:4];
  assign rs1     = ir_q[3:2];
  assign funct   = ir_q[1:0];
  assign imm4    = ir_q[3:0];
  assign br_off  = signed'(imm4);
  assign rd_val  = regs_q[rd];
  assign rs1_val = regs_q[rs1];

  // ALU datapath; results wrap mod 2^DATA_W.
  always_comb begin
    alu_res = '0;
    unique case (funct)
      2'b00: alu_res = rd_val + rs1_val;
      2'b01: alu_res = rd_val - rs1_val;
      2'b10: alu_res = rd_val & rs1_val;
      2'b11: alu_res = rd_val ^ rs1_val;
    endcase
  end

  // Next-state logic for the FSM, architectural state and registered outputs.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    regs_d      = regs_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
`ifdef CORE_MC_RETIRE_CNT_EN
    retire_d    = retire_q;
`endif

    unique case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = '0;
`ifdef CORE_MC_RETIRE_CNT_EN
          retire_d = '0;
`endif
        end
      end

      StFetch: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = StExec;
        end
      end

      StExec: begin
        state_d = StFetch;
        pc_d    = pc_q + PC_W'(1);
`ifdef CORE_MC_RETIRE_CNT_EN
        if (retire_q != 16'hFFFF) begin
          retire_d = retire_q + 16'd1;
        end
`endif
        unique case (op)
          OpAlu: regs_d[rd] = alu_res;
          OpLi:  regs_d[rd] = DATA_W'(imm4);
          OpBeqz: begin
            // Offset is relative to the branch itself; wraps mod 2^PC_W.
            if (rd_val == '0) begin
              pc_d = pc_q + PC_W'(br_off);
            end
          end
          OpSpec: begin
            if (rd == 2'b00) begin
              state_d = StHalt;
              pc_d    = pc_q;
            end else if (rd == 2'b01) begin
              out_data_d  = rd_val;
              out_valid_d = 1'b1;
            end
          end
        endcase
      end
    endcase

    // Status outputs are registered from the next state so they align with it.
    req_d    = (state_d == StFetch);
    busy_d   = (state_d == StFetch) || (state_d == StExec);
    halted_d = (state_d == StHalt);
  end

  // State registers; reset is asynchronous so imem_req drops immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      ir_q        <= '0;
      regs_q      <= '{default: '0};
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
`ifdef CORE_MC_RETIRE_CNT_EN
      retire_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      regs_q      <= regs_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
`ifdef CORE_MC_RETIRE_CNT_EN
      retire_q    <= retire_d;
`endif
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
`ifdef CORE_MC_RETIRE_CNT_EN
  assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_core_mc.sv
// Self-checking bench for core_mc: directed programs plus random programs, all
// checked cycle by cycle against an instruction-level model of the ISA.
module tb_core_mc;
  localparam int DATA_W = 8;
  localparam int PC_W   = 4;
  localparam int MASK   = (1 << DATA_W) - 1;
  localparam int NADDR  = 1 << PC_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [7:0]        imem_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              busy;
  logic              halted;
`ifdef CORE_MC_RETIRE_CNT_EN
  logic [15:0]       retire_cnt;
`endif

  core_mc #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
`ifdef CORE_MC_RETIRE_CNT_EN
    .halted    (halted),
    .retire_cnt(retire_cnt)
`else
    .halted    (halted)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory with a programmable number of wait cycles per fetch.
  logic [7:0] mem [NADDR];
  int         wait_n = 0;
  logic [3:0] wcnt;
  assign imem_data = mem[imem_addr];
  assign imem_ack  = imem_req && (int'(wcnt) >= wait_n);
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wcnt <= '0;
    else                       wcnt <= wcnt + 4'd1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: registers survive HALT/start, cleared only by reset.
  int mregs [4];
  int mlast_out;
  int mretire;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mregs[i] = 0;
    mlast_out = 0;
    mretire   = 0;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < NADDR; i++) mem[i] = v;
  endtask

  // Run the program in mem from address 0 for up to max_n instructions.
  // Leaves the core in FETCH (imem_req high) if it did not halt.
  task automatic run_prog(input int w, input int max_n, output bit did_halt);
    int  pc;
    bit  ov_prev;
    bit  hlt;
    int  ins, op, rd, rs, f, imm, a, b, r, off;
    wait_n   = w;
    did_halt = 1'b0;
    @(negedge clk) start = 1'b1;
    tick();
    start   = 1'b0;
    pc      = 0;
    ov_prev = 1'b0;
    mretire = 0;
    for (int i = 0; i < max_n; i++) begin
      chk("fetch_req", imem_req, 1);
      chk("fetch_addr", imem_addr, pc);
      chk("fetch_busy", busy, 1);
      chk("fetch_halted", halted, 0);
      chk("out_valid", out_valid, ov_prev);
      chk("out_data", out_data, mlast_out);
`ifdef CORE_MC_RETIRE_CNT_EN
      chk("retire_cnt", retire_cnt, mretire);
`endif
      for (int c = 0; c < w; c++) begin
        tick();
        chk("wait_req", imem_req, 1);
        chk("wait_addr", imem_addr, pc);
        chk("wait_out_valid", out_valid, 0);
      end
      tick();
      chk("exec_req", imem_req, 0);
      chk("exec_busy", busy, 1);
      // start while busy must be ignored.
      start = 1'($urandom_range(0, 1));
      // Instruction-level model of the ISA.
      ins = int'(mem[pc]);
      op  = (ins >> 6) & 3;
      rd  = (ins >> 4) & 3;
      rs  = (ins >> 2) & 3;
      f   = ins & 3;
      imm = ins & 15;
      hlt = 1'b0;
      ov_prev = 1'b0;
      a = mregs[rd];
      b = mregs[rs];
      r = (pc + 1) % NADDR;
      case (op)
        0: begin
          case (f)
            0: mregs[rd] = (a + b) & MASK;
            1: mregs[rd] = (a - b) & MASK;
            2: mregs[rd] = a & b;
            default: mregs[rd] = a ^ b;
          endcase
        end
        1: mregs[rd] = imm;
        2: if (a == 0) begin
          off = (imm >= 8) ? imm - 16 : imm;
          r   = (pc + off + NADDR) % NADDR;
        end
        default: begin
          if (rd == 0) hlt = 1'b1;
          else if (rd == 1) begin
            ov_prev   = 1'b1;
            mlast_out = a;
          end
        end
      endcase
      pc = r;
      if (mretire < 65535) mretire++;
      tick();
      start = 1'b0;
      if (hlt) begin
        chk("halt_halted", halted, 1);
        chk("halt_busy", busy, 0);
        chk("halt_req", imem_req, 0);
        chk("halt_out_valid", out_valid, 0);
        chk("halt_out_data", out_data, mlast_out);
`ifdef CORE_MC_RETIRE_CNT_EN
        chk("halt_retire", retire_cnt, mretire);
`endif
        tick();
        chk("halt_stays", halted, 1);
        did_halt = 1'b1;
        break;
      end
    end
  endtask

  // Asynchronous reset while the core is fetching.
  task automatic mid_reset();
    chk("pre_reset_req", imem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_req", imem_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_addr", imem_addr, 0);
`ifdef CORE_MC_RETIRE_CNT_EN
    chk("arst_retire", retire_cnt, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_clear();
  endtask

  bit hd;

  initial begin
    model_clear();
    fill(8'hE0);
    // 1: idle after reset, with start held during reset.
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_req", imem_req, 0);
      chk("idle_busy", busy, 0);
      chk("idle_halted", halted, 0);
      chk("idle_addr", imem_addr, 0);
    end

    // 2/3: straight-line program, zero-wait then 3 wait states.
    for (int w = 0; w <= 3; w += 3) begin
      fill(8'hE0);
      mem[0] = 8'h55; mem[1] = 8'h63; mem[2] = 8'h18; mem[3] = 8'hD0; mem[4] = 8'hC0;
      run_prog(w, 10, hd);
      chk("p2_halted", 32'(hd), 1);
      chk("p2_out", out_data, 8);
    end

    // 4: branch self-loop, then mid-fetch reset.
    fill(8'hE0);
    mem[0] = 8'h40; mem[1] = 8'h8F;
    run_prog(0, 9, hd);
    chk("loop_no_halt", 32'(hd), 0);
    mid_reset();
    // Branch on nonzero falls through.
    fill(8'hE0);
    mem[0] = 8'h61; mem[1] = 8'hA5; mem[2] = 8'hD0; mem[3] = 8'hC0;
    run_prog(1, 10, hd);
    chk("fall_halted", 32'(hd), 1);
    // NOP stream wraps 15 -> 0.
    fill(8'hE0);
    run_prog(1, 20, hd);
    mid_reset();

    // 5: arithmetic wrap.
    fill(8'hE0);
    mem[0] = 8'h50; mem[1] = 8'h61; mem[2] = 8'h19; mem[3] = 8'hD0; mem[4] = 8'hC0;
    run_prog(0, 10, hd);
    chk("sub_out", out_data, 8'hFF);
    fill(8'hE0);
    mem[0] = 8'h5F;
    for (int i = 1; i <= 5; i++) mem[i] = 8'h14;
    mem[6] = 8'hD0; mem[7] = 8'hC0;
    run_prog(2, 12, hd);
    chk("add_out", out_data, 8'hE0);

    // 6: reset mid-run, then registers read back as zero.
    fill(8'hE0);
    mem[0] = 8'h55; mem[1] = 8'h63; mem[2] = 8'h7F; mem[3] = 8'h4A; mem[4] = 8'hC0;
    run_prog(3, 4, hd);
    mid_reset();
    fill(8'hE0);
    mem[0] = 8'hD0; mem[1] = 8'h10; mem[2] = 8'h18; mem[3] = 8'h1C;
    mem[4] = 8'hD0; mem[5] = 8'hC0;
    run_prog(0, 10, hd);
    chk("zero_regs_out", out_data, 0);
    chk("zero_regs_halted", 32'(hd), 1);

    // Random programs against the model.
    for (int p = 0; p < 25; p++) begin
      for (int j = 0; j < NADDR; j++) begin
        case ($urandom_range(0, 7))
          0: mem[j] = 8'hC0;
          1: mem[j] = 8'hD0;
          default: mem[j] = 8'($urandom);
        endcase
      end
      run_prog(int'($urandom_range(0, 3)), 40, hd);
      if (!hd) mid_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
